// File: rtl/add_round_key_seq.sv
// Iterative AddRoundKey engine: a local bank of NR+1 round keys is XORed into an
// NB-column state, CPC columns per cycle, with valid/ready on both sides.
module add_round_key_seq #(
  parameter int NB  = 4,
  parameter int NR  = 10,
  parameter int CPC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_wr_en,
  input  logic [$clog2(NR+1)-1:0] key_wr_round,
  input  logic [$clog2(NB)-1:0]   key_wr_col,
  input  logic [31:0]             key_wr_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(NR+1)-1:0] in_round,
  input  logic [32*NB-1:0]        in_state,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [32*NB-1:0]        out_state,
  output logic                    out_err,
  output logic                    busy
);

  localparam int RW = $clog2(NR+1);
  localparam int CW = $clog2(NB);
  localparam logic [RW-1:0] NR_L     = RW'(NR);
  localparam logic [CW-1:0] COL_MAX  = CW'(NB-1);
  localparam logic [CW-1:0] LAST_COL = CW'(NB-CPC);
  localparam logic [CW-1:0] CPC_L    = CW'(CPC);

  if ((NB % CPC) != 0) begin : g_bad_cpc
    $error("add_round_key_seq: CPC must divide NB");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      col_r;
  logic [RW-1:0]      round_r;
  logic [32*NB-1:0]   work_r;
  logic [32*NB-1:0]   work_next_s;
  logic               out_valid_r;
  logic               out_err_r;
  logic               busy_r;
  logic               round_ok_s;
  logic [31:0]        key_bank_r [NR+1][NB];

  // An out-of-range round selects an all-zero key rather than a bank word.
  assign round_ok_s = (round_r <= NR_L);

  // Each column belongs to a fixed group; it is XORed only while col_r points at that group.
  for (genvar c = 0; c < NB; c++) begin : g_col
    localparam logic [CW-1:0] GRP_COL = CW'((c / CPC) * CPC);
    logic [31:0] key_col_s;
    assign key_col_s = round_ok_s ? key_bank_r[round_r][c] : 32'h0000_0000;
    assign work_next_s[32*c +: 32] = (col_r == GRP_COL) ? (work_r[32*c +: 32] ^ key_col_s)
                                                        : work_r[32*c +: 32];
  end

  // Key bank write port; reads see the pre-write value in the write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r <= NR; r++) begin
        for (int c = 0; c < NB; c++) begin
          key_bank_r[r][c] <= 32'h0000_0000;
        end
      end
    end else if (key_wr_en && (key_wr_round <= NR_L) && (key_wr_col <= COL_MAX)) begin
      key_bank_r[key_wr_round][key_wr_col] <= key_wr_data;
    end
  end

  // Input handshake: free in IDLE, or in DONE when the result leaves this cycle.
  always_comb begin
    case (state_r)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Control FSM, column counter, working register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      col_r       <= {CW{1'b0}};
      round_r     <= {RW{1'b0}};
      work_r      <= {(32*NB){1'b0}};
      out_valid_r <= 1'b0;
      out_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            work_r  <= in_state;
            round_r <= in_round;
            col_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          work_r <= work_next_s;
          if (col_r == LAST_COL) begin
            out_valid_r <= 1'b1;
            out_err_r   <= ~round_ok_s;
            state_r     <= ST_DONE;
          end else begin
            col_r <= col_r + CPC_L;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_err_r   <= 1'b0;
            if (in_valid) begin
              work_r  <= in_state;
              round_r <= in_round;
              col_r   <= {CW{1'b0}};
              state_r <= ST_RUN;
            end else begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          out_err_r   <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_err   = out_err_r;
  assign out_state = work_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_add_round_key_seq.sv
// Self-checking bench for add_round_key_seq: default instance (NB=4, NR=10, CPC=1)
// plus a wide instance (NB=8, NR=14, CPC=2), checked against a whole-state XOR model.
module tb_add_round_key_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_key_wr_en;
  logic [3:0]   a_key_wr_round;
  logic [1:0]   a_key_wr_col;
  logic [31:0]  a_key_wr_data;
  logic         a_in_valid, a_in_ready;
  logic [3:0]   a_in_round;
  logic [127:0] a_in_state;
  logic         a_out_valid, a_out_ready;
  logic [127:0] a_out_state;
  logic         a_out_err, a_busy;

  logic         b_key_wr_en;
  logic [3:0]   b_key_wr_round;
  logic [2:0]   b_key_wr_col;
  logic [31:0]  b_key_wr_data;
  logic         b_in_valid, b_in_ready;
  logic [3:0]   b_in_round;
  logic [255:0] b_in_state;
  logic         b_out_valid, b_out_ready;
  logic [255:0] b_out_state;
  logic         b_out_err, b_busy;

  add_round_key_seq dut_a (
    .clk(clk), .rst(rst),
    .key_wr_en(a_key_wr_en), .key_wr_round(a_key_wr_round), .key_wr_col(a_key_wr_col),
    .key_wr_data(a_key_wr_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_round(a_in_round), .in_state(a_in_state), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_state(a_out_state), .out_err(a_out_err), .busy(a_busy)
  );

  add_round_key_seq #(.NB(8), .NR(14), .CPC(2)) dut_b (
    .clk(clk), .rst(rst),
    .key_wr_en(b_key_wr_en), .key_wr_round(b_key_wr_round), .key_wr_col(b_key_wr_col),
    .key_wr_data(b_key_wr_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_round(b_in_round), .in_state(b_in_state), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_state(b_out_state), .out_err(b_out_err), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] model_key [11];

  typedef struct {
    logic [3:0]   round;
    logic [127:0] state;
    logic [127:0] exp;
    logic         err;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Bytes listed row0-first per column -> byte k of the listing at bits [8k+7:8k].
  function automatic logic [127:0] pack16(input logic [127:0] listed);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = listed[127-8*k -: 8];
    return r;
  endfunction

  function automatic logic [127:0] model_xor(input logic [3:0] round, input logic [127:0] st);
    return (round <= 4'd10) ? (st ^ model_key[round]) : st;
  endfunction

  // Called at a negedge; returns at the next negedge after the write edge.
  task automatic wr_key_a(input int round, input int col, input logic [31:0] data);
    a_key_wr_en    = 1'b1;
    a_key_wr_round = 4'(round);
    a_key_wr_col   = 2'(col);
    a_key_wr_data  = data;
    @(negedge clk);
    a_key_wr_en = 1'b0;
    if (round <= 10) model_key[round][32*col +: 32] = data;
  endtask

  task automatic run_a(input logic [3:0] round, input logic [127:0] st, input logic [127:0] exp,
                       input logic err, input int hold, input string name);
    int lat;
    a_in_valid = 1'b1;
    a_in_round = round;
    a_in_state = st;
    chk({name, "_in_ready"}, 256'(a_in_ready), 256'(1'b1));
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!a_out_valid && lat < 50);
    chk({name, "_latency"}, 256'(lat), 256'(4));
    chk({name, "_state"}, 256'(a_out_state), 256'(exp));
    chk({name, "_err"}, 256'(a_out_err), 256'(err));
    for (int i = 0; i < hold; i++) begin
      a_in_valid = 1'b1;
      @(negedge clk);
      chk({name, "_hold_valid"}, 256'(a_out_valid), 256'(1'b1));
      chk({name, "_hold_state"}, 256'(a_out_state), 256'(exp));
      chk({name, "_hold_in_ready"}, 256'(a_in_ready), 256'(1'b0));
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk({name, "_post_valid"}, 256'(a_out_valid), 256'(1'b0));
    chk({name, "_post_err"}, 256'(a_out_err), 256'(1'b0));
    chk({name, "_post_busy"}, 256'(a_busy), 256'(1'b0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] fips_key, s1, s2, st;
    logic [255:0] bst;
    logic [3:0]   rr;
    int           lat, t1, t2;
    logic         seen;

    rst = 1'b1;
    a_key_wr_en = 1'b0; a_key_wr_round = 4'd0; a_key_wr_col = 2'd0; a_key_wr_data = 32'd0;
    a_in_valid = 1'b0; a_in_round = 4'd0; a_in_state = 128'd0; a_out_ready = 1'b0;
    b_key_wr_en = 1'b0; b_key_wr_round = 4'd0; b_key_wr_col = 3'd0; b_key_wr_data = 32'd0;
    b_in_valid = 1'b0; b_in_round = 4'd0; b_in_state = 256'd0; b_out_ready = 1'b0;
    for (int r = 0; r < 11; r++) model_key[r] = 128'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_in_ready", 256'(a_in_ready), 256'(1'b1));
    chk("reset_busy", 256'(a_busy), 256'(1'b0));
    chk("reset_out_valid", 256'(a_out_valid), 256'(1'b0));
    chk("reset_out_err", 256'(a_out_err), 256'(1'b0));
    chk("reset_out_state", 256'(a_out_state), 256'(0));
    chk("reset_b_in_ready", 256'(b_in_ready), 256'(1'b1));
    chk("reset_b_out_state", 256'(b_out_state), 256'(0));

    // FIPS-197 appendix B round-0 key
    fips_key = pack16(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    for (int c = 0; c < 4; c++) wr_key_a(0, c, fips_key[32*c +: 32]);

    vecs[0] = '{4'd0,  pack16(128'h3243f6a8_885a308d_313198a2_e0370734),
                       pack16(128'h193de3be_a0f4e22b_9ac68d2a_e9f84808), 1'b0};
    vecs[1] = '{4'd13, {16{8'hA5}}, {16{8'hA5}}, 1'b1};
    vecs[2] = '{4'd0,  128'd0, fips_key, 1'b0};
    vecs[3] = '{4'd11, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
                       128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b1};
    for (int i = 0; i < 4; i++)
      run_a(vecs[i].round, vecs[i].state, vecs[i].exp, vecs[i].err, (i == 0) ? 5 : 0,
            $sformatf("vec%0d", i));

    for (int r = 1; r <= 10; r++)
      for (int c = 0; c < 4; c++) wr_key_a(r, c, $urandom);

    // Back-to-back: second accept coincides with the first output handshake
    s1 = {$urandom, $urandom, $urandom, $urandom};
    s2 = {$urandom, $urandom, $urandom, $urandom};
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1; a_in_round = 4'd0; a_in_state = s1;
    @(negedge clk);
    a_in_round = 4'd1; a_in_state = s2;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!a_out_valid && lat < 50);
    t1 = cyc;
    chk("b2b_first_state", 256'(a_out_state), 256'(model_xor(4'd0, s1)));
    chk("b2b_in_ready", 256'(a_in_ready), 256'(1'b1));
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("b2b_busy_after_first", 256'(a_busy), 256'(1'b1));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!a_out_valid && lat < 50);
    t2 = cyc;
    chk("b2b_spacing", 256'(t2 - t1), 256'(5));
    chk("b2b_second_state", 256'(a_out_state), 256'(model_xor(4'd1, s2)));
    @(negedge clk);
    a_out_ready = 1'b0;
    chk("b2b_drained", 256'(a_out_valid), 256'(1'b0));

    // Randomised traffic with occasional key rewrites (rounds 11/12 must be ignored)
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0)
        wr_key_a(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), $urandom);
      rr = 4'($urandom_range(0, 15));
      st = {$urandom, $urandom, $urandom, $urandom};
      run_a(rr, st, model_xor(rr, st), (rr > 4'd10), int'($urandom_range(0, 2)),
            $sformatf("rand%0d_r%0d", i, rr));
    end

    // Wide configuration: round 14 key all ones inverts the state
    for (int c = 0; c < 8; c++) begin
      b_key_wr_en = 1'b1; b_key_wr_round = 4'd14; b_key_wr_col = 3'(c); b_key_wr_data = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    b_key_wr_en = 1'b0;
    for (int k = 0; k < 32; k++) bst[8*k +: 8] = 8'(k);
    for (int pass = 0; pass < 2; pass++) begin
      b_in_valid = 1'b1;
      b_in_round = (pass == 0) ? 4'd14 : 4'd15;
      b_in_state = bst;
      @(negedge clk);
      b_in_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!b_out_valid && lat < 50);
      chk($sformatf("wide%0d_latency", pass), 256'(lat), 256'(4));
      chk($sformatf("wide%0d_state", pass), b_out_state, (pass == 0) ? ~bst : bst);
      chk($sformatf("wide%0d_err", pass), 256'(b_out_err), 256'(pass == 1));
      b_out_ready = 1'b1;
      @(negedge clk);
      b_out_ready = 1'b0;
      chk($sformatf("wide%0d_post_valid", pass), 256'(b_out_valid), 256'(1'b0));
    end

    // Reset asserted in the second RUN cycle
    st = {$urandom, $urandom, $urandom, $urandom};
    a_in_valid = 1'b1; a_in_round = 4'd0; a_in_state = st;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 256'(a_busy), 256'(1'b0));
    chk("rst_in_ready", 256'(a_in_ready), 256'(1'b1));
    seen = a_out_valid;
    repeat (8) begin
      @(negedge clk);
      seen = seen | a_out_valid;
    end
    chk("rst_no_output", 256'(seen), 256'(1'b0));
    for (int r = 0; r < 11; r++) model_key[r] = 128'd0;
    run_a(4'd0, st, model_xor(4'd0, st), 1'b0, 0, "rst_zero_bank");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_round_key_seq.md
Name: add_round_key_seq

Overview:
Iterative, parametrised AddRoundKey engine for the AES/Rijndael cipher datapath. It holds a local bank of NR+1 round keys, written one column at a time. It accepts a full NB-column state plus a round index over a valid/ready handshake and XORs the selected round key into the state, CPC columns per cycle. The result is presented on a valid/ready output. It sits between the MixColumns stage and the next round's SubBytes stage in the iterative cipher core.

Parameters:
NB, 4, state/key columns (4, 6 or 8); each column is 4 bytes.
NR, 10, number of rounds; key bank depth is NR+1 round keys.
CPC, 1, columns processed per cycle; must divide NB (elaboration error otherwise).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
key_wr_en  in  1  key bank write strobe
key_wr_round  in  clog2(NR+1)  round index of write
key_wr_col  in  clog2(NB)  column index of write
key_wr_data  in  32  key column; row r byte at [8r+7:8r]
in_valid  in  1  input state valid
in_ready  out  1  engine can accept a state
in_round  in  clog2(NR+1)  round key to apply
in_state  in  32*NB  state; column c at [32c+31:32c], row r byte at [32c+8r+7:32c+8r]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_state  out  32*NB  state XOR round key, same packing
out_err  out  1  qualified by out_valid; in_round exceeded NR
busy  out  1  FSM not IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset clears:
  - FSM to IDLE, column counter to 0.
  - out_valid=0, out_err=0, out_state=0.
  - All key bank words to 0.
  - After reset: in_ready=1, busy=0.
- Reset mid-operation discards the in-flight state; no output is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready: latch in_state into the working register, latch in_round, set col=0, go to RUN.
- RUN:
  - Each cycle, columns col..col+CPC-1 of the working register ^= key_bank[round][same columns]; col += CPC.
  - On the cycle processing the last group (col = NB-CPC), go to DONE.
- DONE:
  - out_valid=1; out_state = working register, held stable until out_ready.
  - On out_valid&out_ready: if in_valid, accept the new state in the same cycle and go to RUN (in_ready = DONE & out_ready); else go to IDLE.
- Latency: out_valid rises NB/CPC cycles after the accept edge.
  - Throughput: one state per NB/CPC+1 cycles under back-to-back traffic.
- Round out of range (in_round > NR, possible when NR+1 is not a power of 2):
  - Key treated as all-zero; out_state = in_state.
  - out_err=1 for that result only; clears on the handshake.
- Key bank:
  - Synchronous write at the clock edge.
  - A write with key_wr_round > NR is ignored.
  - A read in the same cycle as a write to the same word returns the old value.
  - Writes are permitted at any time. A write to an unprocessed column of the active round takes effect for that column, so the bank write is not snapshotted.
- out_ready is ignored outside DONE.
- in_valid while RUN is ignored (in_ready=0); the upstream stage holds its data.
- Pure bitwise XOR; no width growth, no carries.

Test Plan:
- FIPS-197 B round 0, NB=4, CPC=1:
  - Stimulus: write key 2b7e1516 28aed2a6 abf71588 09cf4f3c into round 0; state 3243f6a8 885a308d 313198a2 e0370734 (bytes listed row0 first per column).
  - Required: out_state 193de3be a0f4e22b 9ac68d2a e9f84808; out_valid exactly 4 cycles after accept; out_err=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE.
  - Required: out_state and out_valid stable; in_ready=0; one result transferred when out_ready rises.
- Back-to-back:
  - Stimulus: in_valid held high; two states with rounds 0 and 1; out_ready=1.
  - Required: second accept on the same cycle as the first output handshake; outputs 5 cycles apart; each matches its expected XOR.
- Configuration NB=8, CPC=2, NR=14:
  - Stimulus: round 14 key of all 0xFF; state 0x00..0x1F.
  - Required: out_state bytes equal bitwise NOT of the input; latency 4 cycles.
- Out-of-range round:
  - Stimulus: NR=10, in_round=13, state 0xA5 per byte.
  - Required: out_state all 0xA5, out_err=1; next valid round gives out_err=0.
- Reset during RUN:
  - Stimulus: assert rst in the 2nd RUN cycle.
  - Required: out_valid never rises for that state; next cycle busy=0, in_ready=1; key bank reads zero (a round-0 XOR returns the input).
